// File: rtl/csr_bank_pkg.sv
// Shared types and helpers for the mode-aware CSR bank.
package csr_bank_pkg;
    localparam int MAX_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        CSR_RW    = 2'd0,
        CSR_RO    = 2'd1,
        CSR_W1C   = 2'd2,
        CSR_PULSE = 2'd3
    } csr_mode_t;

    // Expand byte enables into a bit mask, one byte lane per enable.
    function automatic logic [MAX_DATA_WIDTH-1:0] build_mask(input logic [MAX_DATA_WIDTH/8-1:0] be);
        logic [MAX_DATA_WIDTH-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_DATA_WIDTH/8; b++) m[b*8 +: 8] = {8{be[b]}};
        return m;
    endfunction
endpackage

// File: rtl/csr_bank_cell.sv
// One CSR: mode-dependent next-state selection plus its write strobe.
module csr_bank_cell
    import csr_bank_pkg::*;
#(
    parameter int        DATA_WIDTH = 64,
    parameter csr_mode_t MODE       = CSR_RW,
    parameter bit        COUNTDOWN  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hw_en,
    input  logic [DATA_WIDTH-1:0] hw_data,
    input  logic                  wr_acc,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] mask,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  wr_strobe
);
    localparam int CW = (DATA_WIDTH < 16) ? DATA_WIDTH : 16;

    logic [DATA_WIDTH-1:0] q_nxt, merged, cdown;

    always_comb begin
        merged = (q & ~mask) | (wdata & mask);
        cdown  = '0;
        if (q[CW-1:0] != '0) cdown[CW-1:0] = q[CW-1:0] - CW'(1);
        q_nxt = q;
        case (MODE)
            CSR_RW: begin
                if (hw_en)          q_nxt = hw_data;
                else if (wr_acc)    q_nxt = merged;
                else if (COUNTDOWN) q_nxt = cdown;
            end
            CSR_RO:    q_nxt = hw_en ? hw_data : q;
            // Hardware set is OR'd after the clear so it wins on collision.
            CSR_W1C:   q_nxt = (q & ~(wdata & mask & {DATA_WIDTH{wr_acc}})) | (hw_en ? hw_data : '0);
            CSR_PULSE: q_nxt = hw_en ? hw_data : (wr_acc ? (wdata & mask) : '0);
            default:   q_nxt = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q         <= '0;
            wr_strobe <= 1'b0;
        end else begin
            q         <= q_nxt;
            wr_strobe <= wr_acc && (MODE != CSR_RO);
        end
    end
endmodule

// File: rtl/csr_bank.sv
// Avalon-MM CSR bank: decode, stall, read pipeline, error flag and countdown reset.
module csr_bank
    import csr_bank_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_CSRS     = 16,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1,
    parameter int RESET_CSR    = 1,
    parameter logic [NUM_CSRS-1:0][1:0] CSR_MODE = '0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [ADDR_WIDTH-1:0]               address,
    input  logic                                read,
    input  logic                                write,
    input  logic [DATA_WIDTH-1:0]               writedata,
    input  logic [DATA_WIDTH/8-1:0]             byteenable,
    output logic                                waitrequest,
    output logic [DATA_WIDTH-1:0]               readdata,
    output logic                                readdatavalid,
    input  logic [NUM_CSRS-1:0]                 hw_en,
    input  logic [NUM_CSRS-1:0][DATA_WIDTH-1:0] hw_data,
    output logic [NUM_CSRS-1:0][DATA_WIDTH-1:0] csr_q,
    output logic [NUM_CSRS-1:0]                 wr_strobe,
    output logic                                access_err,
    output logic                                app_reset
);
    localparam int OFFS = $clog2(DATA_WIDTH/8);
    localparam int IW   = ADDR_WIDTH - OFFS;
    localparam int MBW  = MAX_DATA_WIDTH/8;
    localparam int CW   = (DATA_WIDTH < 16) ? DATA_WIDTH : 16;

    logic [IW-1:0]             idx;
    logic [NUM_CSRS-1:0]       sel, stall_vec, wr_acc;
    logic                      in_range, req_acc, rd_acc, cd_nz, cd_nz_d;
    logic [MAX_DATA_WIDTH-1:0] mask_full;
    logic [DATA_WIDTH-1:0]     mask, rd_mux;

    assign idx = address[ADDR_WIDTH-1:OFFS];

    if (OFFS > 0) begin : g_unused
        logic unused_lsb;
        assign unused_lsb = ^address[OFFS-1:0];
    end

    always_comb begin
        sel    = '0;
        rd_mux = '0;
        for (int i = 0; i < NUM_CSRS; i++) begin
            sel[i] = (idx == IW'(i));
            rd_mux = rd_mux | ({DATA_WIDTH{sel[i]}} & csr_q[i]);
        end
    end

    assign in_range    = |sel;
    assign waitrequest = ~rst_n | (write & |(sel & stall_vec));
    assign req_acc     = (read | write) & ~waitrequest;
    assign rd_acc      = read & ~waitrequest;
    assign wr_acc      = {NUM_CSRS{write & ~waitrequest}} & sel;
    assign mask_full   = build_mask(MBW'(byteenable));
    assign mask        = mask_full[DATA_WIDTH-1:0];

    for (genvar i = 0; i < NUM_CSRS; i++) begin : g_csr
        localparam csr_mode_t M = (i == RESET_CSR) ? CSR_RW : csr_mode_t'(CSR_MODE[i]);
        // Only modes whose write would overwrite a hardware load must stall.
        assign stall_vec[i] = hw_en[i] & ((M == CSR_RW) | (M == CSR_PULSE));
        csr_bank_cell #(
            .DATA_WIDTH(DATA_WIDTH),
            .MODE      (M),
            .COUNTDOWN (i == RESET_CSR)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .hw_en    (hw_en[i]),
            .hw_data  (hw_data[i]),
            .wr_acc   (wr_acc[i]),
            .wdata    (writedata),
            .mask     (mask),
            .q        (csr_q[i]),
            .wr_strobe(wr_strobe[i])
        );
    end

    logic [READ_LATENCY:1]                 vld_pipe;
    logic [READ_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            dat_pipe[1] <= rd_mux;
            for (int s = 2; s <= READ_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign readdata      = dat_pipe[READ_LATENCY];
    assign readdatavalid = vld_pipe[READ_LATENCY];

    assign cd_nz = |csr_q[RESET_CSR][CW-1:0];

    // Stretching by one sample makes a count of N hold app_reset for N+1 cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            access_err <= 1'b0;
            app_reset  <= 1'b1;
            cd_nz_d    <= 1'b0;
        end else begin
            access_err <= access_err | (req_acc & ~in_range);
            cd_nz_d    <= cd_nz;
            app_reset  <= cd_nz | cd_nz_d;
        end
    end
endmodule

// File: tb/tb_csr_bank.sv
// Scoreboard bench for csr_bank: directed scenarios then randomized traffic vs a reference model.
module tb_csr_bank;
    import csr_bank_pkg::*;

    localparam int DW = 64, N = 16, AW = 12, RL = 2, RCSR = 1;

    function automatic logic [N-1:0][1:0] mk_modes();
        logic [N-1:0][1:0] m;
        m = '0;
        m[4] = CSR_W1C; m[5] = CSR_PULSE; m[6]  = CSR_RO;
        m[8] = CSR_W1C; m[9] = CSR_PULSE; m[10] = CSR_RO;
        return m;
    endfunction
    localparam logic [N-1:0][1:0] MODES = mk_modes();

    logic clk = 1'b0, rst_n;
    logic [AW-1:0] address;
    logic read, write, waitrequest, readdatavalid, access_err, app_reset;
    logic [DW-1:0] writedata, readdata;
    logic [DW/8-1:0] byteenable;
    logic [N-1:0] hw_en, wr_strobe;
    logic [N-1:0][DW-1:0] hw_data, csr_q;

    csr_bank #(.DATA_WIDTH(DW), .NUM_CSRS(N), .ADDR_WIDTH(AW), .READ_LATENCY(RL),
               .RESET_CSR(RCSR), .CSR_MODE(MODES)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .readdatavalid(readdatavalid), .hw_en(hw_en), .hw_data(hw_data),
        .csr_q(csr_q), .wr_strobe(wr_strobe), .access_err(access_err), .app_reset(app_reset));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic csr_mode_t mode_of(input int i);
        return (i == RCSR) ? CSR_RW : csr_mode_t'(MODES[i]);
    endfunction

    function automatic logic exp_wait();
        int ix;
        ix = int'(address[AW-1:3]);
        if (!rst_n) return 1'b1;
        if (!write || ix >= N) return 1'b0;
        return hw_en[ix] && (mode_of(ix) == CSR_RW || mode_of(ix) == CSR_PULSE);
    endfunction

    // Reference model: register contents, strobes, flags and expected reads.
    typedef struct { logic [63:0] data; int due; } rd_t;
    rd_t rdq[$];
    logic [63:0] mq [N];
    logic [N-1:0] m_strobe;
    logic m_err, m_app, m_nzp;
    bit started = 0;
    int cyc = 0;

    always @(posedge clk) begin : p_model
        int ix;
        logic stall, wacc;
        logic [63:0] msk, merged;
        logic [63:0] nq [N];
        cyc++;
        started = 1;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mq[i] = 64'd0;
            m_strobe = '0; m_err = 0; m_app = 1; m_nzp = 0;
            rdq.delete();
        end else begin
            ix = int'(address[AW-1:3]);
            stall = exp_wait();
            msk = 64'd0;
            for (int b = 0; b < 8; b++) if (byteenable[b]) msk[8*b +: 8] = 8'hFF;
            if (read && !stall) rdq.push_back('{data: (ix < N) ? mq[ix] : 64'd0, due: cyc + RL - 1});
            if ((read || write) && !stall && ix >= N) m_err = 1;
            m_app = (mq[RCSR][15:0] != 16'd0) || m_nzp;
            m_nzp = (mq[RCSR][15:0] != 16'd0);
            for (int i = 0; i < N; i++) begin
                wacc = write && !stall && (ix == i);
                merged = (mq[i] & ~msk) | (writedata & msk);
                case (mode_of(i))
                    CSR_RW: begin
                        if (hw_en[i]) nq[i] = hw_data[i];
                        else if (wacc) nq[i] = merged;
                        else if (i == RCSR) nq[i] = (mq[i][15:0] == 16'd0) ? 64'd0 : 64'(mq[i][15:0]) - 64'd1;
                        else nq[i] = mq[i];
                    end
                    CSR_RO:  nq[i] = hw_en[i] ? hw_data[i] : mq[i];
                    CSR_W1C: nq[i] = (mq[i] & ~(wacc ? (writedata & msk) : 64'd0)) | (hw_en[i] ? hw_data[i] : 64'd0);
                    default: nq[i] = hw_en[i] ? hw_data[i] : (wacc ? (writedata & msk) : 64'd0);
                endcase
                m_strobe[i] = wacc && (mode_of(i) != CSR_RO);
            end
            for (int i = 0; i < N; i++) mq[i] = nq[i];
        end
    end

    // Monitor: compares every output against the model away from the active edge.
    always @(negedge clk) begin : p_mon
        rd_t r;
        logic ev;
        if (started) begin
            chk("waitrequest", waitrequest, exp_wait());
            for (int i = 0; i < N; i++) chk($sformatf("csr_q[%0d]", i), csr_q[i], mq[i]);
            chk("wr_strobe", wr_strobe, m_strobe);
            chk("access_err", access_err, m_err);
            chk("app_reset", app_reset, m_app);
            ev = (rdq.size() > 0) && (rdq[0].due == cyc);
            chk("readdatavalid", readdatavalid, ev);
            if (ev) begin
                r = rdq.pop_front();
                chk("readdata", readdata, r.data);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        read = 0; write = 0; hw_en = '0;
    endtask

    task automatic wr(input int ix, input logic [63:0] d, input logic [7:0] be);
        address = AW'(ix * 8); write = 1; writedata = d; byteenable = be;
    endtask

    task automatic wait_rdv(input string nm, input logic [63:0] exp);
        for (int k = 0; k < 4 && !readdatavalid; k++) step();
        chk({nm, "_valid"}, readdatavalid, 1'b1);
        chk(nm, readdata, exp);
    endtask

    initial begin
        int cnt, ix;
        rst_n = 0; address = '0; writedata = '0; byteenable = '0; hw_data = '0;
        idle();
        repeat (3) step();
        chk("rst_wait", waitrequest, 1'b1);
        chk("rst_app", app_reset, 1'b1);
        chk("rst_err", access_err, 1'b0);
        chk("rst_q2", csr_q[2], 64'd0);
        rst_n = 1;
        step(); step();
        chk("app_release", app_reset, 1'b0);

        wr(2, 64'hFFFFFFFF_FFFFFFFF, 8'hFF); step();
        wr(2, 64'hAABBCCDD_11223344, 8'h0F); step();
        idle(); read = 1; address = AW'(2 * 8);
        chk("rw_q2", csr_q[2], 64'hFFFFFFFF_11223344);
        chk("rw_strobe", wr_strobe[2], 1'b1);
        step(); read = 0;
        chk("rw_strobe_off", wr_strobe[2], 1'b0);
        wait_rdv("rw_readback", 64'hFFFFFFFF_11223344);

        hw_en[3] = 1; hw_data[3] = 64'h1234; wr(3, 64'hCAFE, 8'hFF); #1;
        chk("coll_wait", waitrequest, 1'b1);
        step();
        chk("coll_hw", csr_q[3], 64'h1234);
        hw_en[3] = 0; step(); idle();
        chk("coll_commit", csr_q[3], 64'hCAFE);

        hw_en[4] = 1; hw_data[4] = 64'h0F; step();
        hw_data[4] = 64'h01; wr(4, 64'h05, 8'hFF); step(); idle();
        chk("w1c", csr_q[4], 64'h0B);

        wr(5, 64'h1, 8'hFF); step(); idle();
        chk("pulse_on", csr_q[5], 64'h1);
        step();
        chk("pulse_off", csr_q[5], 64'h0);
        hw_en[6] = 1; hw_data[6] = 64'h55; step(); idle();
        wr(6, 64'h99, 8'hFF); step(); idle();
        chk("ro_hold", csr_q[6], 64'h55);
        chk("ro_strobe", wr_strobe[6], 1'b0);

        wr(1, 64'd3, 8'hFF); step(); idle();
        cnt = 0;
        repeat (8) begin step(); if (app_reset) cnt++; end
        chk("countdown", 64'(cnt), 64'd4);

        read = 1; address = AW'(N * 8); step(); read = 0;
        wait_rdv("oob_read", 64'd0);
        chk("oob_err", access_err, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            read = 1'($urandom); write = 1'($urandom);
            ix = int'($urandom_range(0, N + 1));
            address = AW'(ix * 8 + int'($urandom_range(0, 7)));
            writedata = {$urandom, $urandom};
            if (ix == RCSR) writedata[15:0] = 16'($urandom_range(0, 6));
            byteenable = 8'($urandom);
            for (int i = 0; i < N; i++) begin
                hw_en[i] = ($urandom_range(0, 7) == 0);
                hw_data[i] = {$urandom, $urandom};
            end
            hw_data[RCSR][15:0] = 16'($urandom_range(0, 5));
            step();
        end
        rst_n = 1; idle();
        repeat (RL + 2) step();
        chk("rdq_drained", 64'(rdq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
